// File: rtl/ltc2308_scanner.sv
// LTC2308 round-robin scanner with an Avalon-MM result bank for the HPS.
// Define LTC2308_AVERAGE_EN to report a 4-sample moving average per channel.
module ltc2308_scanner #(
    parameter int NUM_CHANNELS = 8,
    parameter int SCK_HALF     = 2,
    parameter int TCONV_CYCLES = 80,
    parameter bit UNIPOLAR     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        adc_convst,
    output logic        adc_sck,
    output logic        adc_sdi,
    input  logic        adc_sdo,
    output logic        scan_done
);

    localparam int CNT_MAX = (TCONV_CYCLES > SCK_HALF) ? ((TCONV_CYCLES > 2) ? TCONV_CYCLES : 2)
                                                       : ((SCK_HALF > 2) ? SCK_HALF : 2);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CONV, WAIT, SHIFT, STORE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic [3:0]         frame_q, frame_d;
    logic               sck_q, sck_d, sdi_q, sdi_d, convst_q, convst_d, done_q, done_d;
    logic [11:0]        shift_q, shift_d;
    logic               cont_q, cont_d;
    logic [31:0]        scanCount_q, scanCount_d;
    logic [31:0]        rdata_q, rdata_d, rdSel;
    logic [11:0]        result_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] valid_q;

    logic               ctrlWrite, shotReq, storeEn;
    logic [2:0]         sendCh, storeCh, cfgIdx;
    logic [5:0]         cfgWord;

    assign ctrlWrite = avs_write && (avs_address == 4'd8);
    assign shotReq   = ctrlWrite && avs_writedata[1];
    // The last frame of a scan re-sends ch0 so its result can be collected.
    assign sendCh    = (frame_q == 4'(NUM_CHANNELS)) ? 3'd0 : frame_q[2:0];
    assign storeCh   = 3'(frame_q - 4'd1);
    assign cfgWord   = {1'b1, sendCh[0], sendCh[2], sendCh[1], UNIPOLAR, 1'b0};
    assign cfgIdx    = 3'(4'd4 - bit_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        sck_d       = 1'b0;
        sdi_d       = 1'b0;
        shift_d     = shift_q;
        done_d      = 1'b0;
        scanCount_d = scanCount_q;
        storeEn     = 1'b0;
        cont_d      = ctrlWrite ? avs_writedata[0] : cont_q;
        case (state_q)
            IDLE: begin
                frame_d = 4'd0;
                cnt_d   = '0;
                if (cont_q || shotReq) state_d = CONV;
            end
            CONV: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(TCONV_CYCLES - 1)) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    sdi_d   = cfgWord[5];
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                sck_d = sck_q;
                sdi_d = sdi_q;
                if (cnt_q == CNT_W'(SCK_HALF - 1)) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        shift_d = {shift_q[10:0], adc_sdo};
                    end else begin
                        // Falling edge: present the next config bit, zeros after the 6th.
                        bit_d = bit_q + 4'd1;
                        sdi_d = (bit_q < 4'd5) ? cfgWord[cfgIdx] : 1'b0;
                        if (bit_q == 4'd11) state_d = STORE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STORE: begin
                storeEn = (frame_q != 4'd0);
                if (frame_q == 4'(NUM_CHANNELS)) begin
                    done_d      = 1'b1;
                    scanCount_d = scanCount_q + 32'd1;
                    frame_d     = 4'd0;
                    state_d     = cont_q ? CONV : IDLE;
                end else begin
                    frame_d = frame_q + 4'd1;
                    state_d = CONV;
                end
            end
            default: state_d = IDLE;
        endcase
        convst_d = (state_d == CONV);
    end

    always_comb begin
        rdSel = '0;
        if (avs_address == 4'd8) begin
            rdSel = {31'b0, cont_q};
        end else if (avs_address == 4'd9) begin
            rdSel = scanCount_q;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (avs_address == 4'(c)) rdSel = {valid_q[c], 19'b0, result_q[c]};
            end
        end
        rdata_d = avs_read ? rdSel : rdata_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 4'd0;
            frame_q     <= 4'd0;
            sck_q       <= 1'b0;
            sdi_q       <= 1'b0;
            convst_q    <= 1'b0;
            done_q      <= 1'b0;
            shift_q     <= 12'd0;
            cont_q      <= 1'b0;
            scanCount_q <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            sck_q       <= sck_d;
            sdi_q       <= sdi_d;
            convst_q    <= convst_d;
            done_q      <= done_d;
            shift_q     <= shift_d;
            cont_q      <= cont_d;
            scanCount_q <= scanCount_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef LTC2308_AVERAGE_EN
    logic [11:0] hist_q     [NUM_CHANNELS][4];
    logic [13:0] sum_q      [NUM_CHANNELS];
    logic [13:0] sumNext    [NUM_CHANNELS];
    logic [2:0]  storeCnt_q [NUM_CHANNELS];

    // Running sum: drop the oldest sample, add the new one.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            sumNext[c] = sum_q[c] - {2'b00, hist_q[c][3]} + {2'b00, shift_q};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                result_q[c]   <= 12'd0;
                sum_q[c]      <= 14'd0;
                storeCnt_q[c] <= 3'd0;
                for (int k = 0; k < 4; k++) hist_q[c][k] <= 12'd0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (storeEn && (storeCh == 3'(c))) begin
                    hist_q[c][0] <= shift_q;
                    hist_q[c][1] <= hist_q[c][0];
                    hist_q[c][2] <= hist_q[c][1];
                    hist_q[c][3] <= hist_q[c][2];
                    sum_q[c]     <= sumNext[c];
                    result_q[c]  <= sumNext[c][13:2];
                    if (storeCnt_q[c] != 3'd4) storeCnt_q[c] <= storeCnt_q[c] + 3'd1;
                    if (storeCnt_q[c] >= 3'd3) valid_q[c] <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) result_q[c] <= 12'd0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (storeEn && (storeCh == 3'(c))) begin
                    result_q[c] <= shift_q;
                    valid_q[c]  <= 1'b1;
                end
            end
        end
    end
`endif

    assign avs_readdata = rdata_q;
    assign adc_convst   = convst_q;
    assign adc_sck      = sck_q;
    assign adc_sdi      = sdi_q;
    assign scan_done    = done_q;

endmodule

// File: tb/tb_ltc2308_scanner.sv
// Self-checking bench for ltc2308_scanner: behavioural LTC2308 model plus a
// per-channel sample-history reference of what the register bank should hold.
`timescale 1ns/1ps
module tb_ltc2308_scanner;
    localparam int NCH      = 4;
    localparam int SCK_HALF = 2;
    localparam int TCONV    = 80;
    localparam int CLK_PER  = 10;
    localparam int FIRST_SCK_CYCLES = 2 + TCONV + SCK_HALF;
`ifdef LTC2308_AVERAGE_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        adc_convst, adc_sck, adc_sdi, adc_sdo, scan_done;

    always #(CLK_PER / 2) clock = ~clock;

    ltc2308_scanner #(
        .NUM_CHANNELS(NCH), .SCK_HALF(SCK_HALF), .TCONV_CYCLES(TCONV), .UNIPOLAR(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi),
        .adc_sdo(adc_sdo), .scan_done(scan_done)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] expData;
    } readVec_t;

    int vecCount = 0;
    int missCount = 0;

    logic [11:0] chanVal [NCH];
    logic [11:0] hist [NCH][$];
    int          doneCount = 0;
    int          scanSinceReset = 0;

    int          lastCh, sdiCnt, sdoIdx, convstCount;
    logic [11:0] convWord;
    logic [5:0]  cfgBits;
    logic [2:0]  decCh;
    logic [5:0]  sdiLog [$];
    time         tConv, tFirstRise, tSecondRise;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // ADC: converts the channel named by the previous frame's config word,
    // shifts the result MSB first, and changes SDO on SCK falling edges.
    initial begin
        lastCh = -1; sdiCnt = 0; sdoIdx = 0; convstCount = 0;
        convWord = '0; cfgBits = '0; adc_sdo = 1'b0;
        forever begin
            @(posedge adc_convst or posedge adc_sck or negedge adc_sck);
            if (adc_sck) begin
                if (sdiCnt == 0) tFirstRise = $time;
                if (sdiCnt == 1) tSecondRise = $time;
                if (sdiCnt < 6) cfgBits = {cfgBits[4:0], adc_sdi};
                sdiCnt++;
                if (sdiCnt == 6) begin
                    sdiLog.push_back(cfgBits);
                    decCh = {cfgBits[3], cfgBits[2], cfgBits[4]};
                    lastCh = (cfgBits[5] && (int'(decCh) < NCH)) ? int'(decCh) : -1;
                end
            end else if (adc_convst) begin
                convstCount++;
                tConv = $time;
                sdiCnt = 0;
                convWord = (lastCh >= 0) ? chanVal[lastCh] : 12'hFFF;
                sdoIdx = 11;
                adc_sdo = convWord[11];
            end else begin
                if (sdoIdx > 0) begin
                    sdoIdx--;
                    adc_sdo = convWord[sdoIdx];
                end else begin
                    adc_sdo = 1'b0;
                end
            end
        end
    end

    // Reference: each completed scan stores the current analog value of every channel.
    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scanSinceReset = 0;
            for (int c = 0; c < NCH; c++) hist[c].delete();
        end else if (scan_done === 1'b1) begin
            doneCount++;
            scanSinceReset++;
            for (int c = 0; c < NCH; c++) hist[c].push_back(chanVal[c]);
        end
    end

    function automatic logic [31:0] expReg(input int c);
        int n;
        int sum;
        n = hist[c].size();
        sum = 0;
        if (n == 0) return 32'd0;
        if (!AVG) return {1'b1, 19'b0, hist[c][n-1]};
        for (int k = (n > 4) ? n - 4 : 0; k < n; k++) sum += int'(hist[c][k]);
        return {(n >= 4), 19'b0, 12'(sum >> 2)};
    endfunction

    task automatic avsWrite(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clock);
        avs_write = 1'b0;
    endtask

    task automatic avsRead(input logic [3:0] a, output logic [31:0] d);
        @(negedge clock);
        avs_address = a; avs_read = 1'b1;
        @(negedge clock);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic applyStimulus(input logic [31:0] ctrl);
        avsWrite(4'd8, ctrl);
    endtask

    task automatic waitDone(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (doneCount < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(name, doneCount, target);
    endtask

    task automatic checkBank(input string tag);
        logic [31:0] rd;
        for (int c = 0; c < NCH; c++) begin
            avsRead(4'(c), rd);
            checkOutput($sformatf("%s_reg%0d", tag, c), rd, expReg(c));
        end
        avsRead(4'd9, rd);
        checkOutput($sformatf("%s_scancount", tag), rd, scanSinceReset);
    endtask

    initial begin
        #(CLK_PER * 60000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    readVec_t    rstVec [11];
    readVec_t    shotVec [8];
    logic [5:0]  expSdi [5];
    logic [31:0] rd;
    int          c0, d0;
    int          n;
    logic [3:0]  unusedAddr [6];

    initial begin
        for (int i = 0; i < 10; i++) rstVec[i] = '{addr: 4'(i), expData: 32'd0};
        rstVec[10] = '{addr: 4'd15, expData: 32'd0};
        if (AVG) begin
            shotVec[0] = '{4'd0, 32'h0000_0040};
            shotVec[1] = '{4'd1, 32'h0000_0080};
            shotVec[2] = '{4'd2, 32'h0000_00C0};
            shotVec[3] = '{4'd3, 32'h0000_0100};
        end else begin
            shotVec[0] = '{4'd0, 32'h8000_0100};
            shotVec[1] = '{4'd1, 32'h8000_0200};
            shotVec[2] = '{4'd2, 32'h8000_0300};
            shotVec[3] = '{4'd3, 32'h8000_0400};
        end
        shotVec[4] = '{4'd4, 32'd0};
        shotVec[5] = '{4'd8, 32'd0};
        shotVec[6] = '{4'd9, 32'd1};
        shotVec[7] = '{4'd12, 32'd0};
        expSdi[0] = 6'b100010; expSdi[1] = 6'b110010; expSdi[2] = 6'b100110;
        expSdi[3] = 6'b110110; expSdi[4] = 6'b100010;
        unusedAddr[0] = 4'd4; unusedAddr[1] = 4'd7; unusedAddr[2] = 4'd10;
        unusedAddr[3] = 4'd11; unusedAddr[4] = 4'd13; unusedAddr[5] = 4'd15;

        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        for (int c = 0; c < NCH; c++) chanVal[c] = 12'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        $display("[TB] reset state");
        checkOutput("rst_convst", {31'b0, adc_convst}, 32'd0);
        checkOutput("rst_sck", {31'b0, adc_sck}, 32'd0);
        checkOutput("rst_sdi", {31'b0, adc_sdi}, 32'd0);
        checkOutput("rst_done", {31'b0, scan_done}, 32'd0);
        for (int i = 0; i < 11; i++) begin
            avsRead(rstVec[i].addr, rd);
            checkOutput($sformatf("rst_addr%0d", rstVec[i].addr), rd, rstVec[i].expData);
        end

        $display("[TB] single shot");
        for (int c = 0; c < NCH; c++) chanVal[c] = 12'(12'h100 * (c + 1));
        c0 = convstCount; d0 = doneCount; sdiLog.delete();
        applyStimulus(32'd2);
        waitDone(d0 + 1, 2000, "shot_done_wait");
        repeat (300) @(negedge clock);
        checkOutput("shot_convst_pulses", convstCount - c0, 5);
        checkOutput("shot_done_pulses", doneCount - d0, 1);
        checkOutput("shot_sdi_frames", sdiLog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < sdiLog.size()) checkOutput($sformatf("shot_sdi_word%0d", i), {26'b0, sdiLog[i]}, {26'b0, expSdi[i]});
        end
        checkOutput("convst_to_sck", 32'((tFirstRise - tConv) / CLK_PER), FIRST_SCK_CYCLES);
        checkOutput("sck_period", 32'((tSecondRise - tFirstRise) / CLK_PER), 2 * SCK_HALF);
        for (int i = 0; i < 8; i++) begin
            avsRead(shotVec[i].addr, rd);
            checkOutput($sformatf("shot_addr%0d", shotVec[i].addr), rd, shotVec[i].expData);
        end

        $display("[TB] exact SDO capture");
        chanVal[2] = 12'hA5C;
        d0 = doneCount;
        applyStimulus(32'd2);
        waitDone(d0 + 1, 2000, "a5c_done_wait");
        checkBank("a5c");

        $display("[TB] continuous then stop mid-scan");
        d0 = doneCount;
        applyStimulus(32'd1);
        waitDone(d0 + 3, 3000, "cont_three_scans");
        repeat (150) @(negedge clock);
        applyStimulus(32'd0);
        waitDone(d0 + 4, 1500, "cont_final_scan");
        c0 = convstCount;
        repeat (400) @(negedge clock);
        checkOutput("cont_no_more_convst", convstCount - c0, 0);
        checkOutput("cont_done_total", doneCount - d0, 4);
        avsRead(4'd8, rd);
        checkOutput("cont_ctrl_cleared", rd, 32'd0);
        checkBank("cont");

        $display("[TB] randomized shots");
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < NCH; c++) chanVal[c] = 12'($urandom_range(0, 4095));
            c0 = convstCount; d0 = doneCount;
            applyStimulus(32'd2);
            if (k == 0) begin
                repeat (200) @(negedge clock);
                applyStimulus(32'd2);
            end
            waitDone(d0 + 1, 2000, $sformatf("rand%0d_done_wait", k));
            repeat (300) @(negedge clock);
            checkOutput($sformatf("rand%0d_convst", k), convstCount - c0, 5);
            checkBank($sformatf("rand%0d", k));
            avsWrite(unusedAddr[k], $urandom);
            avsRead(unusedAddr[$urandom_range(0, 5)], rd);
            checkOutput($sformatf("rand%0d_unused", k), rd, 32'd0);
        end

        $display("[TB] reset during SHIFT");
        applyStimulus(32'd2);
        n = 0;
        while (adc_sck !== 1'b1 && n < 500) begin
            @(negedge clock);
            n++;
        end
        checkOutput("shift_reached", {31'b0, adc_sck}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_sck", {31'b0, adc_sck}, 32'd0);
        checkOutput("async_rst_convst", {31'b0, adc_convst}, 32'd0);
        checkOutput("async_rst_sdi", {31'b0, adc_sdi}, 32'd0);
        checkOutput("async_rst_rdata", avs_readdata, 32'd0);
        #20;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            avsRead(rstVec[i].addr, rd);
            checkOutput($sformatf("rst2_addr%0d", rstVec[i].addr), rd, rstVec[i].expData);
        end
        for (int c = 0; c < NCH; c++) chanVal[c] = 12'($urandom_range(0, 4095));
        d0 = doneCount;
        applyStimulus(32'd2);
        waitDone(d0 + 1, 2000, "post_rst_done_wait");
        checkBank("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/ltc2308_scanner.md
Name: ltc2308_scanner

Overview:
- Parametrised LTC2308 ADC controller; successor to the fixed single-mode ADC core on the soc_system fabric.
- Autonomously scans NUM_CHANNELS single-ended inputs round-robin and drives CONVST/SCK/SDI/SDO.
- Holds the latest result per channel in an Avalon-MM slave register bank for the HPS.
- Supports continuous and single-shot scan modes.

Parameters:
- NUM_CHANNELS, 8, channels scanned (1..8), always channels 0..NUM_CHANNELS-1.
- SCK_HALF, 2, clk cycles per SCK half-period (>=1).
- TCONV_CYCLES, 80, clk cycles from CONVST rise to first SCK (covers tCONV, 1.6 us at 50 MHz).
- UNIPOLAR, 1, UNI bit of the config word.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- avs_address  in  4  register index
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered, latency 1
- adc_convst  out  1  LTC2308 CONVST
- adc_sck  out  1  LTC2308 SCK
- adc_sdi  out  1  LTC2308 SDI (config word, MSB first)
- adc_sdo  in  1  LTC2308 SDO (result, MSB first)
- scan_done  out  1  one-cycle pulse when a full scan completes

Behaviour:
- Reset values: adc_convst=0, adc_sck=0, adc_sdi=0, avs_readdata=0, scan_done=0, all result registers 0 and invalid, CTRL=0, SCAN_COUNT=0, FSM in IDLE.
- Register map:
  - addr 0..NUM_CHANNELS-1: {valid[31], 19'b0, result[11:0]}.
  - addr 8 CTRL: bit0 = CONT, R/W; bit1 = SHOT, write-1 pulse, reads 0.
  - addr 9 SCAN_COUNT: 32-bit, read-only, wraps at 2^32-1 to 0.
  - Other addresses read 0; writes to them are ignored.
- Reads: avs_readdata is valid the cycle after avs_read.
- Config word for channel c: {1'b1, c[0], c[2], c[1], UNIPOLAR, 1'b0}, shifted during the first 6 SCK cycles, then SDI=0.
- FSM: IDLE -> CONV -> WAIT -> SHIFT -> STORE -> (CONV | IDLE).
  - IDLE: leave when CONT=1 or a SHOT write occurs. Frame counter f=0.
  - CONV: adc_convst=1 for 2 cycles.
  - WAIT: adc_convst=0; count TCONV_CYCLES.
  - SHIFT: 12 SCK periods. SCK rises after SCK_HALF cycles low. SDI changes on SCK falling. SDO is sampled on the clk edge of each SCK rise.
  - STORE: one cycle; writes the result for the channel sent in the previous frame.
- Pipeline latency: the result of frame f belongs to the config sent in frame f-1.
  - Frame 0 of a scan sends ch0 and discards its SDO.
  - A scan is NUM_CHANNELS+1 frames; frame f sends channel f mod NUM_CHANNELS.
- After the STORE of frame NUM_CHANNELS:
  - pulse scan_done and increment SCAN_COUNT;
  - if CONT=1, start a new scan at frame 0; otherwise go to IDLE.
- A SHOT write while busy is ignored.
- Clearing CONT mid-scan lets the current scan finish, then the FSM goes to IDLE.
- NUM_CHANNELS=1: every scan is 2 frames, both sending ch0.
- valid is set on the first store to a channel and never cleared except by reset.
- Reset mid-frame: outputs return to reset values immediately (async). The partial frame is lost; the ADC completes internally and the next frame re-syncs.
- Avalon read and STORE to the same register in the same cycle: the read returns the pre-store value.

Optional Feature:
- Macro LTC2308_AVERAGE_EN.
- Defined:
  - Per-channel 4-deep sample history and 14-bit sum.
  - The result field is sum>>2, truncated.
  - valid is set only after 4 stores to that channel.
  - History and sums are cleared on reset.
- Undefined: the result field is the raw 12-bit sample. No history storage is synthesised.

Test Plan:
- Reset, then read addr 0..9 -> all 0; adc_convst/adc_sck/adc_sdi=0.
- NUM_CHANNELS=4; ADC model returns 0x100*(ch+1); write CTRL=2 (SHOT) -> exactly 5 frames, 5 CONVST pulses; SDI words 100010,110010,100110,110110,100010; regs 0..3 read 0x80000100, 0x80000200, 0x80000300, 0x80000400; scan_done pulses once; SCAN_COUNT=1; FSM returns to IDLE.
- SCK_HALF=2, TCONV_CYCLES=80 -> CONVST rise to first SCK rise = 2+80+2 cycles; 12 SCK periods of 4 clk each; SDO value 0xA5C captured exactly.
- CTRL=1 for 3 scans, then write CTRL=0 mid-scan -> current scan completes; SCAN_COUNT=3 or 4 consistent with scan_done pulses; no further CONVST.
- Assert reset_n low during SHIFT -> adc_sck=0 asynchronously; registers cleared; a subsequent SHOT produces correct values.
- With LTC2308_AVERAGE_EN, CONT=1, ch0 samples 100,200,300,400 -> valid=0 through 3 stores, then 0x800000FA (250).
